// File: rtl/mem_value_predict_buffer.sv
// In-flight value-predicted load buffer: verifies predictions against in-order miss returns.
// Optional MEM_PRED_STATS_EN adds saturating correct/mispredict counters.
module mem_value_predict_buffer #(
   parameter int ADDRESS_WIDTH    = 32,
   parameter int CHECKPOINT_WIDTH = 2,
   parameter int DATA_WIDTH       = 32,
   parameter int REG_ADDR_WIDTH   = 5,
   parameter int FREE_LIST_WIDTH  = 6,
   parameter int DEPTH            = 4
) (
   input  logic                        i_Clk,
   input  logic                        i_Reset,
   input  logic                        i_Alloc_Valid,
   output logic                        o_Alloc_Ready,
   input  logic [ADDRESS_WIDTH-1:0]    i_PC,
   input  logic [CHECKPOINT_WIDTH-1:0] i_Checkpoint,
   input  logic [DATA_WIDTH-1:0]       i_Predicted_Data,
   input  logic [REG_ADDR_WIDTH-1:0]   i_VWrite_Addr,
   input  logic [REG_ADDR_WIDTH:0]     i_PWrite_Addr,
   input  logic [FREE_LIST_WIDTH-1:0]  i_Phys_Active_List_Index,
   input  logic                        i_Mem_Done,
   input  logic [DATA_WIDTH-1:0]       i_Mem_Data,
   input  logic                        i_Flush,
   output logic                        o_Verify,
   output logic                        o_Mispredict,
   output logic                        o_Writes_Back,
   output logic [DATA_WIDTH-1:0]       o_WriteBack_Data,
   output logic [REG_ADDR_WIDTH-1:0]   o_VWrite_Addr,
   output logic [REG_ADDR_WIDTH:0]     o_PWrite_Addr,
   output logic [FREE_LIST_WIDTH-1:0]  o_Phys_Active_List_Index,
   output logic [ADDRESS_WIDTH-1:0]    o_PC,
   output logic [CHECKPOINT_WIDTH-1:0] o_Checkpoint,
   output logic [$clog2(DEPTH):0]      o_Count,
   output logic [15:0]                 o_Correct_Count,
   output logic [15:0]                 o_Mispredict_Count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0]       pred_mem [DEPTH];
   logic [ADDRESS_WIDTH-1:0]    pc_mem   [DEPTH];
   logic [CHECKPOINT_WIDTH-1:0] ckpt_mem [DEPTH];
   logic [REG_ADDR_WIDTH-1:0]   vaddr_mem[DEPTH];
   logic [REG_ADDR_WIDTH:0]     paddr_mem[DEPTH];
   logic [FREE_LIST_WIDTH-1:0]  ali_mem  [DEPTH];

   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic             alloc_fire, alloc_take, pop, match, mis;

   assign o_Alloc_Ready = (count < CNT_W'(DEPTH));
   assign o_Count       = count;

   // Flush squashes everything; a mispredict also drops any same-cycle (younger) allocate.
   always_comb begin
      alloc_fire = i_Alloc_Valid & o_Alloc_Ready & ~i_Flush;
      pop        = i_Mem_Done & (count != '0) & ~i_Flush;
      match      = pop & (i_Mem_Data == pred_mem[head]);
      mis        = pop & ~match;
      alloc_take = alloc_fire & ~mis;
   end

   always_ff @(posedge i_Clk) begin
      if (alloc_fire) begin
         pred_mem[tail]  <= i_Predicted_Data;
         pc_mem[tail]    <= i_PC;
         ckpt_mem[tail]  <= i_Checkpoint;
         vaddr_mem[tail] <= i_VWrite_Addr;
         paddr_mem[tail] <= i_PWrite_Addr;
         ali_mem[tail]   <= i_Phys_Active_List_Index;
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         head                     <= '0;
         tail                     <= '0;
         count                    <= '0;
         o_Verify                 <= 1'b0;
         o_Mispredict             <= 1'b0;
         o_Writes_Back            <= 1'b0;
         o_WriteBack_Data         <= '0;
         o_VWrite_Addr            <= '0;
         o_PWrite_Addr            <= '0;
         o_Phys_Active_List_Index <= '0;
         o_PC                     <= '0;
         o_Checkpoint             <= '0;
      end else begin
         o_Verify      <= match;
         o_Mispredict  <= mis;
         o_Writes_Back <= mis;
         if (pop) begin
            o_WriteBack_Data         <= i_Mem_Data;
            o_VWrite_Addr            <= vaddr_mem[head];
            o_PWrite_Addr            <= paddr_mem[head];
            o_Phys_Active_List_Index <= ali_mem[head];
            o_PC                     <= pc_mem[head];
            o_Checkpoint             <= ckpt_mem[head];
         end
         if (i_Flush) begin
            head  <= tail;
            count <= '0;
         end else if (mis) begin
            head  <= head + 1'b1;
            tail  <= head + 1'b1;
            count <= '0;
         end else begin
            if (pop) head <= head + 1'b1;
            if (alloc_take) tail <= tail + 1'b1;
            unique case ({alloc_take, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

`ifdef MEM_PRED_STATS_EN
   logic [15:0] correct_q, mispredict_q;

   // Counted on the same edge that raises the corresponding pulse.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         correct_q    <= '0;
         mispredict_q <= '0;
      end else begin
         if (match && correct_q != 16'hFFFF) correct_q <= correct_q + 16'd1;
         if (mis && mispredict_q != 16'hFFFF) mispredict_q <= mispredict_q + 16'd1;
      end
   end

   assign o_Correct_Count    = correct_q;
   assign o_Mispredict_Count = mispredict_q;
`else
   assign o_Correct_Count    = '0;
   assign o_Mispredict_Count = '0;
`endif

endmodule

// File: tb/tb_mem_value_predict_buffer.sv
// Table-driven bench for mem_value_predict_buffer plus hand sequences for stats and async reset.
module tb_mem_value_predict_buffer;

   logic        i_Clk = 1'b0;
   logic        i_Reset;
   logic        i_Alloc_Valid;
   logic        o_Alloc_Ready;
   logic [31:0] i_PC;
   logic [1:0]  i_Checkpoint;
   logic [31:0] i_Predicted_Data;
   logic [4:0]  i_VWrite_Addr;
   logic [5:0]  i_PWrite_Addr;
   logic [5:0]  i_Phys_Active_List_Index;
   logic        i_Mem_Done;
   logic [31:0] i_Mem_Data;
   logic        i_Flush;
   logic        o_Verify, o_Mispredict, o_Writes_Back;
   logic [31:0] o_WriteBack_Data;
   logic [4:0]  o_VWrite_Addr;
   logic [5:0]  o_PWrite_Addr;
   logic [5:0]  o_Phys_Active_List_Index;
   logic [31:0] o_PC;
   logic [1:0]  o_Checkpoint;
   logic [2:0]  o_Count;
   logic [15:0] o_Correct_Count, o_Mispredict_Count;

   int n_vec = 0;
   int n_err = 0;

   always #5 i_Clk = ~i_Clk;

   mem_value_predict_buffer dut (
      .i_Clk                    (i_Clk),
      .i_Reset                  (i_Reset),
      .i_Alloc_Valid            (i_Alloc_Valid),
      .o_Alloc_Ready            (o_Alloc_Ready),
      .i_PC                     (i_PC),
      .i_Checkpoint             (i_Checkpoint),
      .i_Predicted_Data         (i_Predicted_Data),
      .i_VWrite_Addr            (i_VWrite_Addr),
      .i_PWrite_Addr            (i_PWrite_Addr),
      .i_Phys_Active_List_Index (i_Phys_Active_List_Index),
      .i_Mem_Done               (i_Mem_Done),
      .i_Mem_Data               (i_Mem_Data),
      .i_Flush                  (i_Flush),
      .o_Verify                 (o_Verify),
      .o_Mispredict             (o_Mispredict),
      .o_Writes_Back            (o_Writes_Back),
      .o_WriteBack_Data         (o_WriteBack_Data),
      .o_VWrite_Addr            (o_VWrite_Addr),
      .o_PWrite_Addr            (o_PWrite_Addr),
      .o_Phys_Active_List_Index (o_Phys_Active_List_Index),
      .o_PC                     (o_PC),
      .o_Checkpoint             (o_Checkpoint),
      .o_Count                  (o_Count),
      .o_Correct_Count          (o_Correct_Count),
      .o_Mispredict_Count       (o_Mispredict_Count)
   );

   typedef struct {
      logic        a;      // allocate
      logic [31:0] pc;
      logic [1:0]  ck;
      logic [31:0] pd;     // predicted data
      logic        dn;     // mem done
      logic [31:0] md;     // mem data
      logic        fl;     // flush
      logic        e_v;
      logic        e_m;
      logic [2:0]  e_cnt;
      logic        e_chk;  // compare data/metadata outputs
      logic [31:0] e_wd;
      logic [31:0] e_pc;
      logic [1:0]  e_ck;
   } vec_t;

   vec_t vecs[$];

   // Metadata is derived from the PC so entries are distinguishable.
   function automatic logic [4:0] va_of(input logic [31:0] pc);
      return pc[4:0] ^ 5'h15;
   endfunction
   function automatic logic [5:0] pa_of(input logic [31:0] pc);
      return pc[9:4] ^ 6'h2A;
   endfunction
   function automatic logic [5:0] ali_of(input logic [31:0] pc);
      return pc[11:6] + 6'd3;
   endfunction

   function automatic vec_t mk(input logic a, input logic [31:0] pc, input logic [1:0] ck,
                               input logic [31:0] pd, input logic dn, input logic [31:0] md,
                               input logic fl, input logic e_v, input logic e_m,
                               input logic [2:0] e_cnt, input logic e_chk,
                               input logic [31:0] e_wd, input logic [31:0] e_pc,
                               input logic [1:0] e_ck);
      vec_t v;
      v.a = a; v.pc = pc; v.ck = ck; v.pd = pd; v.dn = dn; v.md = md; v.fl = fl;
      v.e_v = e_v; v.e_m = e_m; v.e_cnt = e_cnt; v.e_chk = e_chk;
      v.e_wd = e_wd; v.e_pc = e_pc; v.e_ck = e_ck;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic cycle(input logic a, input logic [31:0] pc, input logic [1:0] ck,
                        input logic [31:0] pd, input logic dn, input logic [31:0] md,
                        input logic fl);
      @(negedge i_Clk);
      i_Alloc_Valid            = a;
      i_PC                     = pc;
      i_Checkpoint             = ck;
      i_Predicted_Data         = pd;
      i_VWrite_Addr            = va_of(pc);
      i_PWrite_Addr            = pa_of(pc);
      i_Phys_Active_List_Index = ali_of(pc);
      i_Mem_Done               = dn;
      i_Mem_Data               = md;
      i_Flush                  = fl;
      @(posedge i_Clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge i_Clk);
      i_Reset = 1'b1;
      @(negedge i_Clk);
      i_Reset = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_verify"}, 64'(o_Verify), 64'd0);
      chk({tag, "_mispred"}, 64'(o_Mispredict), 64'd0);
      chk({tag, "_wb"}, 64'(o_Writes_Back), 64'd0);
      chk({tag, "_wbdata"}, 64'(o_WriteBack_Data), 64'd0);
      chk({tag, "_meta"}, {o_VWrite_Addr, o_PWrite_Addr, o_Phys_Active_List_Index}, 64'd0);
      chk({tag, "_pc"}, 64'(o_PC), 64'd0);
      chk({tag, "_ckpt"}, 64'(o_Checkpoint), 64'd0);
      chk({tag, "_count"}, 64'(o_Count), 64'd0);
      chk({tag, "_ready"}, 64'(o_Alloc_Ready), 64'd1);
      chk({tag, "_stats"}, {o_Correct_Count, o_Mispredict_Count}, 64'd0);
   endtask

   initial begin
      i_Reset = 1'b1;
      i_Alloc_Valid = 0; i_PC = '0; i_Checkpoint = '0; i_Predicted_Data = '0;
      i_VWrite_Addr = '0; i_PWrite_Addr = '0; i_Phys_Active_List_Index = '0;
      i_Mem_Done = 0; i_Mem_Data = '0; i_Flush = 0;

      //          a  pc     ck pd     dn md     fl  v  m  cnt chk wd     pc     ck
      // basic match
      vecs.push_back(mk(1, 'h100, 0, 'h1234, 0, 0,      0, 0, 0, 1, 0, 0,      0,     0));
      vecs.push_back(mk(0, 0,     0, 0,      1, 'h1234, 0, 1, 0, 0, 1, 'h1234, 'h100, 0));
      // mismatch squashes younger B
      vecs.push_back(mk(1, 'h200, 1, 'h5,    0, 0,      0, 0, 0, 1, 0, 0,      0,     0));
      vecs.push_back(mk(1, 'h300, 2, 'h6,    0, 0,      0, 0, 0, 2, 0, 0,      0,     0));
      vecs.push_back(mk(0, 0,     0, 0,      1, 'h7,    0, 0, 1, 0, 1, 'h7,    'h200, 1));
      vecs.push_back(mk(0, 0,     0, 0,      0, 0,      0, 0, 0, 0, 1, 'h7,    'h200, 1));
      // fill, ignored fifth allocate, in-order drain with wrap
      vecs.push_back(mk(1, 'h400, 0, 'hA0,   0, 0,      0, 0, 0, 1, 0, 0,      0,     0));
      vecs.push_back(mk(1, 'h410, 1, 'hA1,   0, 0,      0, 0, 0, 2, 0, 0,      0,     0));
      vecs.push_back(mk(1, 'h420, 2, 'hA2,   0, 0,      0, 0, 0, 3, 0, 0,      0,     0));
      vecs.push_back(mk(1, 'h430, 3, 'hA3,   0, 0,      0, 0, 0, 4, 0, 0,      0,     0));
      vecs.push_back(mk(1, 'h440, 0, 'hA4,   0, 0,      0, 0, 0, 4, 0, 0,      0,     0));
      vecs.push_back(mk(0, 0,     0, 0,      1, 'hA0,   0, 1, 0, 3, 1, 'hA0,   'h400, 0));
      vecs.push_back(mk(0, 0,     0, 0,      1, 'hA1,   0, 1, 0, 2, 1, 'hA1,   'h410, 1));
      vecs.push_back(mk(0, 0,     0, 0,      1, 'hA2,   0, 1, 0, 1, 1, 'hA2,   'h420, 2));
      vecs.push_back(mk(0, 0,     0, 0,      1, 'hA3,   0, 1, 0, 0, 1, 'hA3,   'h430, 3));
      vecs.push_back(mk(1, 'h500, 2, 'hB0,   0, 0,      0, 0, 0, 1, 0, 0,      0,     0));
      vecs.push_back(mk(0, 0,     0, 0,      1, 'hB0,   0, 1, 0, 0, 1, 'hB0,   'h500, 2));
      // same-cycle allocate with match, then with mismatch
      vecs.push_back(mk(1, 'h600, 0, 'hC0,   0, 0,      0, 0, 0, 1, 0, 0,      0,     0));
      vecs.push_back(mk(1, 'h610, 1, 'hC1,   0, 0,      0, 0, 0, 2, 0, 0,      0,     0));
      vecs.push_back(mk(1, 'h620, 2, 'hC2,   1, 'hC0,   0, 1, 0, 2, 1, 'hC0,   'h600, 0));
      vecs.push_back(mk(1, 'h630, 3, 'hC3,   1, 'hFF,   0, 0, 1, 0, 1, 'hFF,   'h610, 1));
      vecs.push_back(mk(0, 0,     0, 0,      1, 'hC3,   0, 0, 0, 0, 1, 'hFF,   'h610, 1));
      // flush beats completion and allocate; empty completion ignored
      vecs.push_back(mk(1, 'h700, 0, 'hD0,   0, 0,      0, 0, 0, 1, 0, 0,      0,     0));
      vecs.push_back(mk(1, 'h710, 1, 'hD1,   0, 0,      0, 0, 0, 2, 0, 0,      0,     0));
      vecs.push_back(mk(1, 'h720, 2, 'hD2,   0, 0,      0, 0, 0, 3, 0, 0,      0,     0));
      vecs.push_back(mk(1, 'h730, 3, 'hD3,   1, 'hD0,   1, 0, 0, 0, 1, 'hFF,   'h610, 1));
      vecs.push_back(mk(0, 0,     0, 0,      1, 'hD1,   0, 0, 0, 0, 1, 'hFF,   'h610, 1));
      vecs.push_back(mk(1, 'h740, 1, 'hE0,   0, 0,      0, 0, 0, 1, 0, 0,      0,     0));
      vecs.push_back(mk(0, 0,     0, 0,      1, 'hE0,   0, 1, 0, 0, 1, 'hE0,   'h740, 1));

      repeat (2) @(posedge i_Clk);
      #1;
      chk_all_zero("reset");
      @(negedge i_Clk);
      i_Reset = 1'b0;

      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         cycle(v.a, v.pc, v.ck, v.pd, v.dn, v.md, v.fl);
         chk($sformatf("v%0d_verify", i), 64'(o_Verify), 64'(v.e_v));
         chk($sformatf("v%0d_mispred", i), 64'(o_Mispredict), 64'(v.e_m));
         chk($sformatf("v%0d_wb", i), 64'(o_Writes_Back), 64'(v.e_m));
         chk($sformatf("v%0d_count", i), 64'(o_Count), 64'(v.e_cnt));
         chk($sformatf("v%0d_ready", i), 64'(o_Alloc_Ready), 64'(v.e_cnt != 3'd4));
         if (v.e_chk) begin
            chk($sformatf("v%0d_wbdata", i), 64'(o_WriteBack_Data), 64'(v.e_wd));
            chk($sformatf("v%0d_pc", i), 64'(o_PC), 64'(v.e_pc));
            chk($sformatf("v%0d_ckpt", i), 64'(o_Checkpoint), 64'(v.e_ck));
            chk($sformatf("v%0d_meta", i),
                {o_VWrite_Addr, o_PWrite_Addr, o_Phys_Active_List_Index},
                {va_of(v.e_pc), pa_of(v.e_pc), ali_of(v.e_pc)});
         end
      end

      // Statistics: 3 matches then 2 mismatches from a clean reset
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cycle(1, 32'h800 + 32'(k), 0, 32'h10 + 32'(k), 0, 0, 0);
         cycle(0, 0, 0, 0, 1, 32'h10 + 32'(k), 0);
      end
      for (int k = 0; k < 2; k++) begin
         cycle(1, 32'h900 + 32'(k), 0, 32'h1, 0, 0, 0);
         cycle(0, 0, 0, 0, 1, 32'h2, 0);
      end
      cycle(0, 0, 0, 0, 0, 0, 1);
`ifdef MEM_PRED_STATS_EN
      chk("stats_correct", 64'(o_Correct_Count), 64'd3);
      chk("stats_mispred", 64'(o_Mispredict_Count), 64'd2);
`else
      chk("stats_correct_off", 64'(o_Correct_Count), 64'd0);
      chk("stats_mispred_off", 64'(o_Mispredict_Count), 64'd0);
`endif

      // Asynchronous reset while a mispredict pulse is live
      cycle(1, 32'hA00, 3, 32'h55, 0, 0, 0);
      cycle(1, 32'hA10, 2, 32'h66, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 32'h99, 0);
      chk("pre_reset_mispred", 64'(o_Mispredict), 64'd1);
      chk("pre_reset_ckpt", 64'(o_Checkpoint), 64'd3);
      i_Mem_Done = 1'b0;
      i_Reset    = 1'b1;
      #1;
      chk_all_zero("midreset");
      @(negedge i_Clk);
      i_Reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
